// File: rtl/funcunit_ctrl.sv
// Multi-cycle sequencer issuing ALU ops and PC-relative branches to the 16-bit function unit.
// Every output except INSTR_READY is registered alongside the FSM state.
module funcunit_ctrl #(
  parameter int unsigned PC_W = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            INSTR_VALID,
  input  logic [15:0]     INSTR,
  output logic            INSTR_READY,
  output logic [3:0]      FS,
  output logic [2:0]      AA,
  output logic [2:0]      BA,
  output logic [2:0]      DA,
  output logic            RW,
  input  logic            V,
  input  logic            C,
  input  logic            N,
  input  logic            Z,
  output logic [PC_W-1:0] PC,
  output logic [3:0]      FLAGS,
  output logic            BR_TAKEN,
  output logic            DONE
);

  localparam logic [3:0] FsHold = 4'b1111;

  typedef enum logic [1:0] {StIdle, StIssue, StWb, StBr} state_t;

  state_t          state;
  logic [11:0]     ir;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] pc_inc;

  // FLAGS is ordered {V,C,N,Z}
  function automatic logic cond_met(input logic [2:0] cc, input logic [3:0] f);
    logic r;
    case (cc)
      3'b000:  r = 1'b1;
      3'b001:  r = f[0];
      3'b010:  r = ~f[0];
      3'b011:  r = f[1];
      3'b100:  r = ~f[1];
      3'b101:  r = f[2];
      3'b110:  r = f[3];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign off_ext     = PC_W'($signed(ir[8:0]));
  assign pc_inc      = PC + PC_W'(1);
  assign INSTR_READY = (state == StIdle) && !RESET;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= StIdle;
      ir       <= '0;
      PC       <= '0;
      FLAGS    <= '0;
      FS       <= FsHold;
      AA       <= '0;
      BA       <= '0;
      DA       <= '0;
      RW       <= 1'b0;
      BR_TAKEN <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      // Outputs are loaded for the state being entered; anything not loaded falls to idle values.
      FS       <= FsHold;
      AA       <= '0;
      BA       <= '0;
      DA       <= '0;
      RW       <= 1'b0;
      BR_TAKEN <= 1'b0;
      DONE     <= 1'b0;
      case (state)
        StIdle: begin
          if (INSTR_VALID) begin
            ir <= INSTR[11:0];
            if (INSTR[15:12] != 4'hF) begin
              state <= StIssue;
              FS    <= INSTR[15:12];
              AA    <= INSTR[8:6];
              BA    <= INSTR[5:3];
            end else begin
              // FLAGS cannot change before the branch resolves, so decide it now.
              state    <= StBr;
              BR_TAKEN <= cond_met(INSTR[11:9], FLAGS);
              DONE     <= 1'b1;
            end
          end
        end
        StIssue: begin
          state <= StWb;
          RW    <= 1'b1;
          DA    <= ir[11:9];
          AA    <= ir[8:6];
          BA    <= ir[5:3];
          DONE  <= 1'b1;
        end
        StWb: begin
          FLAGS <= {V, C, N, Z};
          PC    <= pc_inc;
          state <= StIdle;
        end
        StBr: begin
          PC    <= BR_TAKEN ? pc_inc + off_ext : pc_inc;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_funcunit_ctrl.sv
// Self-checking bench for funcunit_ctrl: a program-order model pushes expected retire results
// into a queue that each scenario pops when the sequencer pulses DONE.
module tb_funcunit_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        INSTR_VALID = 1'b0;
  logic [15:0] INSTR = 16'h0000;
  logic        INSTR_READY;
  logic [3:0]  FS;
  logic [2:0]  AA, BA, DA;
  logic        RW;
  logic        V = 1'b0, C = 1'b0, N = 1'b0, Z = 1'b0;
  logic [7:0]  PC;
  logic [3:0]  FLAGS;
  logic        BR_TAKEN;
  logic        DONE;

  funcunit_ctrl #(.PC_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .INSTR(INSTR),
    .INSTR_READY(INSTR_READY), .FS(FS), .AA(AA), .BA(BA), .DA(DA), .RW(RW),
    .V(V), .C(C), .N(N), .Z(Z), .PC(PC), .FLAGS(FLAGS), .BR_TAKEN(BR_TAKEN), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] pc;
    logic [3:0] flags;
    logic       taken;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_pc = 8'h00;
  logic [3:0] m_flags = 4'h0;
  int         passed = 0;
  int         total = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         rw_cnt = 0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (DONE) done_cnt <= done_cnt + 1;
    if (RW) rw_cnt <= rw_cnt + 1;
  end

  function automatic logic cc_model(input logic [2:0] cc, input logic [3:0] f);
    logic v, c, n, z;
    {v, c, n, z} = f;
    case (cc)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return c;
      3'd6: return v;
      default: return 1'b0;
    endcase
  endfunction

  // Present a word, push its expected retire result, and return #1 after the accepting edge.
  task automatic send(input logic [15:0] w, input logic [3:0] fu, input bit hold,
                      output int acc);
    exp_t e;
    int   n = 0;
    int   off;
    INSTR       = w;
    INSTR_VALID = 1'b1;
    {V, C, N, Z} = fu;
    if (w[15:12] == 4'hF) begin
      off     = w[8] ? int'(w[8:0]) - 512 : int'(w[8:0]);
      e.taken = cc_model(w[11:9], m_flags);
      e.pc    = 8'(int'(m_pc) + 1 + (e.taken ? off : 0));
      e.flags = m_flags;
    end else begin
      e.taken = 1'b0;
      e.pc    = m_pc + 8'd1;
      e.flags = fu;
    end
    m_pc    = e.pc;
    m_flags = e.flags;
    sb.push_back(e);
    while (!INSTR_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!INSTR_READY) begin
      total++;
      $display("FAIL accept_timeout ready=%b want 1 for word %h", INSTR_READY, w);
    end
    @(posedge CLK);
    #1;
    acc = cyc;
    if (!hold) INSTR_VALID = 1'b0;
  endtask

  task automatic wait_done(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge CLK);
      seen = DONE;
    end
  endtask

  task automatic test_reset;
    RESET       = 1'b1;
    INSTR_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total++;
    if (INSTR_READY !== 1'b0) $display("FAIL reset_ready got %b want 0", INSTR_READY);
    else passed++;
    total++;
    if ({FS, RW, AA, BA, DA, BR_TAKEN, DONE} !== {4'hF, 1'b0, 9'd0, 2'b00})
      $display("FAIL reset_outputs got fs=%h rw=%b aa=%0d ba=%0d da=%0d br=%b done=%b",
               FS, RW, AA, BA, DA, BR_TAKEN, DONE);
    else passed++;
    total++;
    if (PC !== 8'h00 || FLAGS !== 4'h0)
      $display("FAIL reset_state got pc=%h flags=%b want 00/0000", PC, FLAGS);
    else passed++;
    RESET = 1'b0;
    #1;
    total++;
    if (INSTR_READY !== 1'b1) $display("FAIL ready_after_reset got %b want 1", INSTR_READY);
    else passed++;
    m_pc    = 8'h00;
    m_flags = 4'h0;
    sb.delete();
  endtask

  task automatic test_alu;
    exp_t e;
    int   acc;
    send(16'h2A50, 4'b1010, 1'b0, acc);
    @(negedge CLK);
    total++;
    if ({FS, AA, BA, RW, DONE, INSTR_READY} !== {4'h2, 3'd1, 3'd2, 3'b000})
      $display("FAIL alu_issue got fs=%h aa=%0d ba=%0d rw=%b done=%b rdy=%b want 2/1/2/0/0/0",
               FS, AA, BA, RW, DONE, INSTR_READY);
    else passed++;
    @(negedge CLK);
    total++;
    if ({RW, DA, AA, BA, FS, DONE, INSTR_READY} !== {1'b1, 3'd5, 3'd1, 3'd2, 4'hF, 2'b10})
      $display("FAIL alu_wb got rw=%b da=%0d aa=%0d ba=%0d fs=%h done=%b rdy=%b want 1/5/1/2/f/1/0",
               RW, DA, AA, BA, FS, DONE, INSTR_READY);
    else passed++;
    e = sb.pop_front();
    @(negedge CLK);
    total++;
    if (PC !== e.pc || FLAGS !== e.flags)
      $display("FAIL alu_retire got pc=%h flags=%b want %h/%b", PC, FLAGS, e.pc, e.flags);
    else passed++;
    total++;
    if ({INSTR_READY, DONE} !== 2'b10)
      $display("FAIL alu_idle got rdy=%b done=%b want 1/0", INSTR_READY, DONE);
    else passed++;
  endtask

  task automatic test_branch_z;
    exp_t e;
    int   acc;
    logic seen;
    test_reset();
    send(16'hA720, 4'b0001, 1'b0, acc);
    wait_done(seen);
    e = sb.pop_front();
    @(negedge CLK);
    total++;
    if (!seen || FLAGS !== e.flags)
      $display("FAIL zflag_sample got done=%b flags=%b want 1/%b", seen, FLAGS, e.flags);
    else passed++;
    send(16'hF3FC, 4'b0000, 1'b0, acc);
    wait_done(seen);
    e = sb.pop_front();
    total++;
    if (!seen || BR_TAKEN !== e.taken)
      $display("FAIL bz_taken got done=%b br=%b want 1/%b", seen, BR_TAKEN, e.taken);
    else passed++;
    @(negedge CLK);
    total++;
    if (PC !== e.pc || PC !== 8'hFE)
      $display("FAIL bz_target got pc=%h want %h", PC, e.pc);
    else passed++;
  endtask

  task automatic test_branch_not_taken;
    exp_t       e;
    int         acc;
    logic       seen;
    logic [7:0] pc0;
    send(16'h2A50, 4'b0000, 1'b0, acc);
    wait_done(seen);
    void'(sb.pop_front());
    @(negedge CLK);
    pc0 = PC;
    send(16'hF3FC, 4'b1110, 1'b0, acc);
    wait_done(seen);
    e = sb.pop_front();
    total++;
    if (!seen || BR_TAKEN !== 1'b0)
      $display("FAIL bnz_taken got done=%b br=%b want 1/0", seen, BR_TAKEN);
    else passed++;
    @(negedge CLK);
    total++;
    if (PC !== e.pc || PC !== pc0 + 8'd1 || FLAGS !== 4'b0000)
      $display("FAIL bnz_pc got pc=%h flags=%b want %h/0000", PC, FLAGS, e.pc);
    else passed++;
  endtask

  task automatic test_wrap;
    logic [15:0] words[3] = '{16'hF1FC, 16'hF003, 16'hFE03};
    logic [7:0]  want[3]  = '{8'hFD, 8'h01, 8'h02};
    exp_t        e;
    int          acc;
    logic        seen;
    test_reset();
    for (int i = 0; i < 3; i++) begin
      send(words[i], 4'b0000, 1'b0, acc);
      wait_done(seen);
      e = sb.pop_front();
      total++;
      if (!seen || BR_TAKEN !== e.taken)
        $display("FAIL wrap_taken[%0d] got done=%b br=%b want 1/%b", i, seen, BR_TAKEN, e.taken);
      else passed++;
      @(negedge CLK);
      total++;
      if (PC !== e.pc || PC !== want[i])
        $display("FAIL wrap_pc[%0d] got %h want %h", i, PC, want[i]);
      else passed++;
    end
  endtask

  task automatic test_cond_codes;
    logic [3:0] fsets[2] = '{4'b1010, 4'b0101};
    exp_t       e;
    int         acc;
    logic       seen;
    for (int s = 0; s < 2; s++) begin
      send(16'h0000, fsets[s], 1'b0, acc);
      wait_done(seen);
      e = sb.pop_front();
      @(negedge CLK);
      total++;
      if (FLAGS !== e.flags) $display("FAIL cc_flags[%0d] got %b want %b", s, FLAGS, e.flags);
      else passed++;
      for (int cc = 0; cc < 8; cc++) begin
        send({4'hF, 3'(cc), 9'd1}, 4'b0000, 1'b0, acc);
        wait_done(seen);
        e = sb.pop_front();
        total++;
        if (!seen || BR_TAKEN !== e.taken)
          $display("FAIL cc_taken[%0d/%0d] got done=%b br=%b want 1/%b",
                   s, cc, seen, BR_TAKEN, e.taken);
        else passed++;
        @(negedge CLK);
        total++;
        if (PC !== e.pc) $display("FAIL cc_pc[%0d/%0d] got %h want %h", s, cc, PC, e.pc);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] words[4] = '{16'h2A50, 16'h3B58, 16'hF002, 16'h1C20};
    logic [3:0]  fus[4]   = '{4'b0011, 4'b1000, 4'b1000, 4'b0110};
    int          acc, prev, d0, r0;
    logic        seen;
    exp_t        e;
    d0   = done_cnt;
    r0   = rw_cnt;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      send(words[i], fus[i], i < 3, acc);
      if (i > 0) begin
        total++;
        if (acc - prev !== ((words[i-1][15:12] == 4'hF) ? 2 : 3))
          $display("FAIL b2b_interval[%0d] got %0d cycles want %0d", i, acc - prev,
                   (words[i-1][15:12] == 4'hF) ? 2 : 3);
        else passed++;
      end
      prev = acc;
    end
    wait_done(seen);
    while (sb.size() > 1) void'(sb.pop_front());
    e = sb.pop_front();
    @(negedge CLK);
    total++;
    if (!seen || PC !== e.pc || FLAGS !== e.flags)
      $display("FAIL b2b_final got done=%b pc=%h flags=%b want 1/%h/%b",
               seen, PC, FLAGS, e.pc, e.flags);
    else passed++;
    repeat (4) @(negedge CLK);
    total++;
    if (done_cnt - d0 !== 4 || rw_cnt - r0 !== 3)
      $display("FAIL b2b_counts got done=%0d rw=%0d want 4/3", done_cnt - d0, rw_cnt - r0);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int   acc, d0, r0;
    logic seen;
    send(16'h2A50, 4'b1111, 1'b0, acc);
    wait_done(seen);
    void'(sb.pop_front());
    @(negedge CLK);
    send(16'h3B58, 4'b0000, 1'b0, acc);
    d0    = done_cnt;
    r0    = rw_cnt;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    total++;
    if ({FS, RW, AA, BA, DA, DONE, BR_TAKEN} !== {4'hF, 1'b0, 9'd0, 2'b00})
      $display("FAIL midreset_outputs got fs=%h rw=%b aa=%0d ba=%0d da=%0d done=%b",
               FS, RW, AA, BA, DA, DONE);
    else passed++;
    total++;
    if (PC !== 8'h00 || FLAGS !== 4'h0 || INSTR_READY !== 1'b0)
      $display("FAIL midreset_state got pc=%h flags=%b rdy=%b want 00/0000/0",
               PC, FLAGS, INSTR_READY);
    else passed++;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    total++;
    if (INSTR_READY !== 1'b1) $display("FAIL midreset_ready got %b want 1", INSTR_READY);
    else passed++;
    repeat (3) @(negedge CLK);
    total++;
    if (done_cnt !== d0 || rw_cnt !== r0 || PC !== 8'h00)
      $display("FAIL midreset_discard got done+%0d rw+%0d pc=%h want 0/0/00",
               done_cnt - d0, rw_cnt - r0, PC);
    else passed++;
    sb.delete();
    m_pc    = 8'h00;
    m_flags = 4'h0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch_z();
    test_branch_not_taken();
    test_wrap();
    test_cond_codes();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/funcunit_ctrl.md
Name: funcunit_ctrl

Overview:
- Multi-cycle control sequencer that drives the 16-bit function unit; it is the issuing side of the FS/status-flag interface.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them into FS and register-file addresses (AA/BA/DA/RW).
- Samples the function unit's V/C/N/Z into a status register.
- Executes conditional PC-relative branches against that status register.

Parameters:
- PC_W, 8, program-counter width; PC wraps modulo 2^PC_W.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- INSTR_VALID  in  1  instruction present on INSTR.
- INSTR  in  16  instruction word; must be held stable while INSTR_VALID=1 and INSTR_READY=0.
- INSTR_READY  out  1  sequencer can accept an instruction this cycle.
- FS  out  4  function select to the function unit.
- AA  out  3  register-file A read address.
- BA  out  3  register-file B read address.
- DA  out  3  register-file write address.
- RW  out  1  register-file write enable; writes function-unit D to DA.
- V, C, N, Z  in  1 each  function-unit status; valid in the same cycle as its registered D.
- PC  out  PC_W  program counter.
- FLAGS  out  4  stored status, ordered {V,C,N,Z}.
- BR_TAKEN  out  1  one-cycle pulse when a branch is taken.
- DONE  out  1  one-cycle pulse when an instruction retires.

Behaviour:
- Instruction format:
  - OP=INSTR[15:12], DR=INSTR[11:9], SA=INSTR[8:6], SB=INSTR[5:3].
  - Branch format: CC=INSTR[11:9], OFF=INSTR[8:0] (signed, two's complement).
- OP 0000-1110 is an ALU op with FS=OP. OP 1111 is a branch; it never issues FS 1111 as an operation.
- FSM states: IDLE, ISSUE, WB, BR.
- IDLE:
  - INSTR_READY=1.
  - On INSTR_VALID=1, latch INSTR. Go to ISSUE if OP!=1111, else go to BR.
- ISSUE:
  - Drive FS=OP, AA=SA, BA=SB.
  - The function unit registers D at the end of this cycle.
  - Always go to WB.
- WB:
  - Drive RW=1, DA=DR, AA=SA, BA=SB; FS=1111 (D hold).
  - FLAGS <= {V,C,N,Z} sampled this cycle.
  - PC <= PC+1; DONE=1; go to IDLE.
- BR:
  - Evaluate CC against stored FLAGS: 000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 C, 110 V, 111 never.
  - If taken: PC <= PC+1+sext(OFF), truncated to PC_W; BR_TAKEN=1.
  - Otherwise: PC <= PC+1.
  - DONE=1; FLAGS unchanged; go to IDLE.
- Default outputs outside the state where they are driven: FS=1111, RW=0, AA=BA=DA=0, BR_TAKEN=0, DONE=0.
- INSTR_READY is 0 in ISSUE, WB and BR.
- Latency from accept edge to DONE pulse: ALU op 2 cycles (3-cycle occupancy); branch 1 cycle (2-cycle occupancy).
- Maximum throughput: one ALU op per 3 cycles.
- INSTR_VALID while INSTR_READY=0 is ignored and no instruction is lost; the producer holds the word until accepted.
- PC arithmetic is modulo 2^PC_W. Backward offsets wrap below 0; forward offsets wrap past 2^PC_W-1.
- Reset values (RESET=1 at an edge, including mid-instruction):
  - State=IDLE, PC=0, FLAGS=0000.
  - INSTR_READY=0 during the reset cycle, then 1.
  - FS=1111, RW=0, AA=BA=DA=0, BR_TAKEN=0, DONE=0.
  - An in-flight instruction is discarded: no RW pulse, no DONE.

Test Plan:
- Reset, then INSTR=0x2A50 (OP=0010 A+B, DR=5, SA=1, SB=2) -> ISSUE cycle FS=0010 AA=1 BA=2; next cycle RW=1 DA=5 DONE=1; PC 0->1; INSTR_READY low for exactly 2 cycles.
- ALU op where the function unit returns Z=1, others 0 (e.g. OP=1010 XOR with SA=SB) -> FLAGS=0001; then branch 0xF3FC (CC=001, OFF=-4) -> BR_TAKEN=1, PC=1+1-4 wrapped = 0xFE (PC_W=8).
- Same branch with FLAGS Z=0 -> BR_TAKEN=0, PC incremented by 1, FLAGS unchanged.
- CC=000 OFF=+3 at PC=0xFD -> PC=0x01 (forward wrap); CC=111 -> never taken.
- INSTR_VALID held high with back-to-back instructions -> each accepted only in IDLE; no instruction dropped or duplicated; INSTR changes only after acceptance.
- RESET asserted during the ISSUE cycle -> no RW pulse, no DONE; PC=0, FLAGS=0, FS=1111; INSTR_READY=1 the cycle after reset deasserts.
